// File: rtl/reel_spin_ctrl.sv
// Per-frame reel scroll sequencer: accelerate, cruise, decelerate, then crawl onto the target symbol.
// Drives the sprite-core slot bus with registered single-cycle writes (bypass, then y0/ctrl every frame).
module reel_spin_ctrl #(
    parameter int NUM_SYM       = 8,
    parameter int SYM_H         = 32,
    parameter int Y_BASE        = 100,
    parameter int MAX_SPEED     = 8,
    parameter int CRUISE_FRAMES = 60
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           frame_tick,
    input  logic                                           start,
    input  logic [((NUM_SYM > 1) ? $clog2(NUM_SYM) : 1)-1:0] stop_sym,
    output logic                                           busy,
    output logic                                           done,
    output logic [4:0]                                     cur_sym,
    output logic                                           cs,
    output logic                                           write,
    output logic [13:0]                                    addr,
    output logic [31:0]                                    wr_data
);
    localparam int STRIP = NUM_SYM * SYM_H;
    localparam int LOG_H = $clog2(SYM_H);
    localparam int PW    = $clog2(STRIP);
    localparam int CW    = (CRUISE_FRAMES > 1) ? $clog2(CRUISE_FRAMES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_ACCEL, S_CRUISE, S_DECEL, S_CRAWL, S_WY, S_WC, S_FIN
    } state_t;

    state_t         state_q, ret_q;
    logic [PW-1:0]  pos_q, tgt_q, pos_d;
    logic [PW:0]    speed_q, step, sum;
    logic [CW-1:0]  cnt_q;
    logic           pend_q, fin_q, busy_q, done_q, cs_q;
    logic [13:0]    addr_q;
    logic [31:0]    wdat_q;
    logic           move;

    assign move = frame_tick | pend_q;

    // Next scroll position for the current phase; speed never exceeds SYM_H so one wrap suffices.
    always_comb begin
        step = speed_q;
        if (state_q == S_CRUISE)
            step = (PW+1)'(MAX_SPEED);
        else if (state_q == S_CRAWL)
            step = (PW+1)'(1);
        sum = {1'b0, pos_q} + step;
        if (sum >= (PW+1)'(STRIP))
            sum = sum - (PW+1)'(STRIP);
        pos_d = sum[PW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            speed_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
        end else begin
            cs_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tgt_q   <= PW'({stop_sym, {LOG_H{1'b0}}});
                        speed_q <= (PW+1)'(1);
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                        fin_q   <= 1'b0;
                        cs_q    <= 1'b1;
                        addr_q  <= 14'h2000;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (frame_tick)
                        pend_q <= 1'b1;
                    state_q <= S_ACCEL;
                end
                S_ACCEL, S_CRUISE, S_DECEL, S_CRAWL: begin
                    if (move) begin
                        pend_q  <= 1'b0;
                        pos_q   <= pos_d;
                        cs_q    <= 1'b1;
                        addr_q  <= 14'h2002;
                        wdat_q  <= 32'(Y_BASE) - 32'(pos_d[LOG_H-1:0]);
                        state_q <= S_WY;
                        ret_q   <= state_q;
                        case (state_q)
                            S_ACCEL: begin
                                if (speed_q == (PW+1)'(MAX_SPEED)) begin
                                    ret_q <= S_CRUISE;
                                    cnt_q <= '0;
                                end else begin
                                    speed_q <= speed_q + 1'b1;
                                end
                            end
                            S_CRUISE: begin
                                if (cnt_q == CW'(CRUISE_FRAMES - 1)) begin
                                    speed_q <= (PW+1)'(MAX_SPEED - 1);
                                    ret_q   <= (MAX_SPEED == 1) ? S_CRAWL : S_DECEL;
                                    if (MAX_SPEED == 1)
                                        speed_q <= (PW+1)'(1);
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end
                            S_DECEL: begin
                                if (speed_q == (PW+1)'(1))
                                    ret_q <= S_CRAWL;
                                else
                                    speed_q <= speed_q - 1'b1;
                            end
                            default: fin_q <= (pos_d == tgt_q);
                        endcase
                    end
                end
                S_WY: begin
                    if (frame_tick)
                        pend_q <= 1'b1;
                    cs_q    <= 1'b1;
                    addr_q  <= 14'h2003;
                    wdat_q  <= 32'(cur_sym);
                    state_q <= S_WC;
                end
                S_WC: begin
                    if (frame_tick)
                        pend_q <= 1'b1;
                    if (fin_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        state_q <= ret_q;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    pend_q  <= 1'b0;
                    fin_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cur_sym = 5'(pos_q >> LOG_H);
    assign busy    = busy_q;
    assign done    = done_q;
    assign cs      = cs_q;
    assign write   = cs_q;
    assign addr    = addr_q;
    assign wr_data = wdat_q;
endmodule
